// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand stage bus: ID-side capture inputs, EX/MEM and MEM/WB forwarding
// sources, pipeline control, and the registered EX-side outputs.
interface id_ex_operand_stage_if #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 8
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rn;
  logic [REG_AW-1:0] id_rm;
  logic [REG_AW-1:0] id_rd;
  logic [DATA_W-1:0] id_rdata1;
  logic [DATA_W-1:0] id_rdata2;
  logic [DATA_W-1:0] id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_memread;
  logic              id_regwrite;

  logic              mem_regwrite;
  logic [REG_AW-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              wb_regwrite;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;

  logic              hold;
  logic              flush;
  logic              load_use_stall;

  logic              ex_valid;
  logic              ex_memread;
  logic              ex_regwrite;
  logic [REG_AW-1:0] ex_rn;
  logic [REG_AW-1:0] ex_rm;
  logic [REG_AW-1:0] ex_rd;
  logic [DATA_W-1:0] ex_opa;
  logic [DATA_W-1:0] ex_opb;
  logic [DATA_W-1:0] ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;

  modport master (
    output id_valid, id_rn, id_rm, id_rd, id_rdata1, id_rdata2, id_imm, id_ctrl,
           id_memread, id_regwrite, mem_regwrite, mem_rd, mem_data,
           wb_regwrite, wb_rd, wb_data, hold, flush,
    input  load_use_stall, ex_valid, ex_memread, ex_regwrite, ex_rn, ex_rm, ex_rd,
           ex_opa, ex_opb, ex_imm, ex_ctrl
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_rd, id_rdata1, id_rdata2, id_imm, id_ctrl,
           id_memread, id_regwrite, mem_regwrite, mem_rd, mem_data,
           wb_regwrite, wb_rd, wb_data, hold, flush,
    output load_use_stall, ex_valid, ex_memread, ex_regwrite, ex_rn, ex_rm, ex_rd,
           ex_opa, ex_opb, ex_imm, ex_ctrl
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM + MEM/WB operand forwarding and load-use bubbles.
// Optional WB_BYPASS_EN: latch same-cycle writeback data instead of stale regfile reads.
module id_ex_operand_stage #(
  parameter int DATA_W   = 64,
  parameter int REG_AW   = 5,
  parameter int CTRL_W   = 8,
  parameter int ZERO_REG = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  id_ex_operand_stage_if.slave  bus
);
  localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

  typedef struct packed {
    logic              valid;
    logic              memread;
    logic              regwrite;
    logic [REG_AW-1:0] rn;
    logic [REG_AW-1:0] rm;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] imm;
    logic [CTRL_W-1:0] ctrl;
  } stage_t;

  stage_t stage_q, stage_d, bubble;
  logic   stall;
  logic [DATA_W-1:0] cap_opa, cap_opb;

  always_comb begin
    bubble    = '0;
    bubble.rd = ZR;
  end

  // Load-use hazard: only the registered EX load and the live ID indices matter.
  assign stall = bus.id_valid & stage_q.valid & stage_q.memread & (stage_q.rd != ZR) &
                 ((stage_q.rd == bus.id_rn) | (stage_q.rd == bus.id_rm));

`ifdef WB_BYPASS_EN
  always_comb begin
    cap_opa = bus.id_rdata1;
    cap_opb = bus.id_rdata2;
    if (bus.wb_regwrite && bus.wb_rd == bus.id_rn && bus.id_rn != ZR) cap_opa = bus.wb_data;
    if (bus.wb_regwrite && bus.wb_rd == bus.id_rm && bus.id_rm != ZR) cap_opb = bus.wb_data;
  end
`else
  assign cap_opa = bus.id_rdata1;
  assign cap_opb = bus.id_rdata2;
`endif

  // NOTE: every field gets a value on every path (defaulted first), so no latch is inferred.
  always_comb begin
    stage_d = stage_q;
    if (bus.flush) begin
      stage_d = bubble;
    end else if (bus.hold) begin
      stage_d = stage_q;
    end else if (stall) begin
      stage_d = bubble;
    end else begin
      stage_d.valid    = bus.id_valid;
      stage_d.memread  = bus.id_memread;
      stage_d.regwrite = bus.id_regwrite;
      stage_d.rn       = bus.id_rn;
      stage_d.rm       = bus.id_rm;
      stage_d.rd       = bus.id_rd;
      stage_d.opa      = cap_opa;
      stage_d.opb      = cap_opb;
      stage_d.imm      = bus.id_imm;
      stage_d.ctrl     = bus.id_ctrl;
    end
  end

  // NOTE: state updates use non-blocking assignment; reset is sampled on the clock edge only.
  always_ff @(posedge clk) begin
    if (!reset) stage_q <= bubble;
    else        stage_q <= stage_d;
  end

  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_AW-1:0] idx,
    input logic [DATA_W-1:0] latched,
    input logic              mem_we,
    input logic [REG_AW-1:0] mem_rd,
    input logic [DATA_W-1:0] mem_data,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_rd,
    input logic [DATA_W-1:0] wb_data
  );
    if (idx == ZR)                    return latched;
    else if (mem_we && mem_rd == idx) return mem_data;
    else if (wb_we && wb_rd == idx)   return wb_data;
    else                              return latched;
  endfunction

  assign bus.ex_opa = fwd(stage_q.rn, stage_q.opa, bus.mem_regwrite, bus.mem_rd, bus.mem_data,
                          bus.wb_regwrite, bus.wb_rd, bus.wb_data);
  assign bus.ex_opb = fwd(stage_q.rm, stage_q.opb, bus.mem_regwrite, bus.mem_rd, bus.mem_data,
                          bus.wb_regwrite, bus.wb_rd, bus.wb_data);

  assign bus.load_use_stall = stall;
  assign bus.ex_valid       = stage_q.valid;
  assign bus.ex_memread     = stage_q.memread;
  assign bus.ex_regwrite    = stage_q.regwrite;
  assign bus.ex_rn          = stage_q.rn;
  assign bus.ex_rm          = stage_q.rm;
  assign bus.ex_rd          = stage_q.rd;
  assign bus.ex_imm         = stage_q.imm;
  assign bus.ex_ctrl        = stage_q.ctrl;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, capture, forwarding priority,
// load-use bubbles, hold/flush, and the optional WB_BYPASS_EN capture path.
module tb_id_ex_operand_stage;
  logic clk;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  id_ex_operand_stage_if #(.DATA_W(64), .REG_AW(5), .CTRL_W(8)) bus ();

  id_ex_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic valid, input logic [4:0] rn, input logic [4:0] rm,
                          input logic [4:0] rd, input logic [63:0] d1, input logic [63:0] d2,
                          input logic [63:0] imm, input logic [7:0] ctrl,
                          input logic memread, input logic regwrite);
    bus.id_valid    = valid;
    bus.id_rn       = rn;
    bus.id_rm       = rm;
    bus.id_rd       = rd;
    bus.id_rdata1   = d1;
    bus.id_rdata2   = d2;
    bus.id_imm      = imm;
    bus.id_ctrl     = ctrl;
    bus.id_memread  = memread;
    bus.id_regwrite = regwrite;
  endtask

  initial begin
    // 1: reset with random inputs
    reset = 1'b0;
    drive_id(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), {$urandom, $urandom},
             {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 1'($urandom), 1'($urandom));
    bus.mem_regwrite = 1'($urandom); bus.mem_rd = 5'($urandom); bus.mem_data = {$urandom, $urandom};
    bus.wb_regwrite  = 1'($urandom); bus.wb_rd  = 5'($urandom); bus.wb_data  = {$urandom, $urandom};
    bus.hold = 1'($urandom); bus.flush = 1'($urandom);
    step();
    step();
    bus.mem_regwrite = 1'b0; bus.wb_regwrite = 1'b0;
    #1;
    check("rst_valid",    64'(bus.ex_valid), 64'd0);
    check("rst_memread",  64'(bus.ex_memread), 64'd0);
    check("rst_regwrite", 64'(bus.ex_regwrite), 64'd0);
    check("rst_rd",       64'(bus.ex_rd), 64'd31);
    check("rst_opa",      bus.ex_opa, 64'd0);
    check("rst_imm",      bus.ex_imm, 64'd0);
    check("rst_ctrl",     64'(bus.ex_ctrl), 64'd0);
    check("rst_stall",    64'(bus.load_use_stall), 64'd0);

    // 2: plain capture
    reset = 1'b1; bus.hold = 1'b0; bus.flush = 1'b0;
    bus.mem_rd = 5'd0; bus.wb_rd = 5'd0;
    drive_id(1'b1, 5'd1, 5'd2, 5'd4, 64'h11, 64'h22, 64'h5, 8'h3C, 1'b0, 1'b1);
    step();
    check("cap_opa",   bus.ex_opa, 64'h11);
    check("cap_opb",   bus.ex_opb, 64'h22);
    check("cap_valid", 64'(bus.ex_valid), 64'd1);
    check("cap_rd",    64'(bus.ex_rd), 64'd4);
    check("cap_imm",   bus.ex_imm, 64'h5);
    check("cap_ctrl",  64'(bus.ex_ctrl), 64'h3C);

    // 3: forwarding priority, then XZR never forwarded
    drive_id(1'b1, 5'd5, 5'd6, 5'd10, 64'h55, 64'h66, 64'h0, 8'h00, 1'b0, 1'b1);
    step();
    bus.hold = 1'b1;
    bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd5; bus.mem_data = 64'hAA;
    bus.wb_regwrite  = 1'b1; bus.wb_rd  = 5'd5; bus.wb_data  = 64'hBB;
    #1;
    check("fwd_mem_wins", bus.ex_opa, 64'hAA);
    check("fwd_opb_none", bus.ex_opb, 64'h66);
    bus.mem_regwrite = 1'b0;
    #1;
    check("fwd_wb",       bus.ex_opa, 64'hBB);
    bus.hold = 1'b0;
    bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd31; bus.wb_rd = 5'd31;
    drive_id(1'b1, 5'd31, 5'd6, 5'd10, 64'h1F, 64'h66, 64'h0, 8'h00, 1'b0, 1'b1);
    step();
    check("fwd_xzr_latched", bus.ex_opa, 64'h1F);
    bus.mem_regwrite = 1'b0; bus.wb_regwrite = 1'b0;

    // 4: load-use hazard and retry, then load to XZR
    drive_id(1'b1, 5'd1, 5'd2, 5'd3, 64'h0, 64'h0, 64'h0, 8'h00, 1'b1, 1'b1);
    step();
    drive_id(1'b1, 5'd8, 5'd3, 5'd12, 64'h8, 64'h3, 64'h0, 8'h00, 1'b0, 1'b1);
    #1;
    check("lu_stall", 64'(bus.load_use_stall), 64'd1);
    step();
    check("lu_bubble_valid", 64'(bus.ex_valid), 64'd0);
    check("lu_bubble_rd",    64'(bus.ex_rd), 64'd31);
    check("lu_stall_clear",  64'(bus.load_use_stall), 64'd0);
    step();
    check("lu_retry_valid", 64'(bus.ex_valid), 64'd1);
    check("lu_retry_rd",    64'(bus.ex_rd), 64'd12);
    drive_id(1'b1, 5'd1, 5'd2, 5'd31, 64'h0, 64'h0, 64'h0, 8'h00, 1'b1, 1'b1);
    step();
    drive_id(1'b1, 5'd31, 5'd31, 5'd13, 64'h0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b1);
    #1;
    check("lu_xzr_nostall", 64'(bus.load_use_stall), 64'd0);

    // 5: hold freezes, flush beats hold
    drive_id(1'b1, 5'd1, 5'd2, 5'd9, 64'h0, 64'h0, 64'h99, 8'h5A, 1'b0, 1'b1);
    step();
    bus.hold = 1'b1;
    drive_id(1'b1, 5'd3, 5'd4, 5'd20, 64'h0, 64'h0, 64'hFF, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_rd",   64'(bus.ex_rd), 64'd9);
      check("hold_imm",  bus.ex_imm, 64'h99);
    end
    check("hold_ctrl", 64'(bus.ex_ctrl), 64'h5A);
    bus.flush = 1'b1;
    step();
    check("flush_valid", 64'(bus.ex_valid), 64'd0);
    check("flush_rd",    64'(bus.ex_rd), 64'd31);
    check("flush_imm",   bus.ex_imm, 64'd0);
    check("flush_regwr", 64'(bus.ex_regwrite), 64'd0);
    bus.flush = 1'b0; bus.hold = 1'b0;

    // 6: same-cycle writeback captured only with WB_BYPASS_EN
    drive_id(1'b1, 5'd7, 5'd7, 5'd14, 64'h0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b1);
    bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 64'h77;
    step();
    bus.wb_regwrite = 1'b0;
    #1;
`ifdef WB_BYPASS_EN
    check("bypass_opa", bus.ex_opa, 64'h77);
    check("bypass_opb", bus.ex_opb, 64'h77);
`else
    check("bypass_opa", bus.ex_opa, 64'h00);
    check("bypass_opb", bus.ex_opb, 64'h00);
`endif

    // synchronous reset mid-stream
    reset = 1'b0;
    step();
    check("rst2_valid", 64'(bus.ex_valid), 64'd0);
    check("rst2_rd",    64'(bus.ex_rd), 64'd31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
